// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, reads instruction memory and fills IF/ID.
// Handles hazard stalls, ID-stage branch/jump redirects and end-of-program detection.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 50,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_instr_i,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             jump_i,
    input  logic [25:0]      jump_index_i,
    output logic [31:0]      if_id_instr_o,
    output logic [31:0]      if_id_pc_plus4_o,
    output logic             if_id_valid_o,
    output logic             prog_done_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    localparam logic [31:0] ImemBytes = 32'(IMEM_WORDS * 4);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      if_id_instr_q, if_id_instr_d;
    logic [31:0]      if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic             if_id_valid_q, if_id_valid_d;
    logic             prog_done_q, prog_done_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic        out_of_range;

    assign pc_plus4     = pc_q + 32'd4;
    assign jump_target  = {if_id_pc_plus4_q[31:28], jump_index_i, 2'b00};
    assign out_of_range = (pc_q >= ImemBytes);

    always_comb begin
        pc_d             = pc_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_valid_d    = if_id_valid_q;
        prog_done_d      = prog_done_q;
        fetch_count_d    = fetch_count_q;

        // Off the end of the image: freeze PC and bubble forever, redirects ignored.
        if (prog_done_q || out_of_range) begin
            prog_done_d      = 1'b1;
            if_id_instr_d    = 32'h0;
            if_id_pc_plus4_d = 32'h0;
            if_id_valid_d    = 1'b0;
        end else if (jump_i || branch_taken_i) begin
            pc_d             = jump_i ? jump_target : {branch_target_i[31:2], 2'b00};
            if_id_instr_d    = 32'h0;
            if_id_pc_plus4_d = 32'h0;
            if_id_valid_d    = 1'b0;
        end else if (!stall_i) begin
            pc_d             = pc_plus4;
            if_id_instr_d    = imem_instr_i;
            if_id_pc_plus4_d = pc_plus4;
            if_id_valid_d    = 1'b1;
            if (fetch_count_q != {CNT_W{1'b1}}) begin
                fetch_count_d = fetch_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q             <= {RESET_PC[31:2], 2'b00};
            if_id_instr_q    <= 32'h0;
            if_id_pc_plus4_q <= 32'h0;
            if_id_valid_q    <= 1'b0;
            prog_done_q      <= 1'b0;
            fetch_count_q    <= '0;
        end else begin
            pc_q             <= pc_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_valid_q    <= if_id_valid_d;
            prog_done_q      <= prog_done_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    assign imem_addr_o      = pc_q;
    assign if_id_instr_o    = if_id_instr_q;
    assign if_id_pc_plus4_o = if_id_pc_plus4_q;
    assign if_id_valid_o    = if_id_valid_q;
    assign prog_done_o      = prog_done_q;
    assign fetch_count_o    = fetch_count_q;

endmodule
